// File: rtl/lc3_mem_model_if.sv
// lc3_mem_model_if
// Bundles the LC3 fetch port, data port, backdoor load port and error counter
// so the memory responder and the bench connect with one object.
//   slave  : memory side (lc3_mem_model) - takes requests, drives data/pulses
//   master : LC3 / bench side - drives requests, observes data/pulses
// Signals:
//   instrmem_rd, pc                 : instruction fetch request and address
//   Instr_dout, complete_instr      : fetched word and one-cycle completion
//   data_req, Data_rd, Data_addr,
//   Data_din                        : data request, 1=read/0=write, addr, wdata
//   Data_dout, complete_data        : read word and one-cycle completion
//   load_en, load_addr, load_data   : backdoor preload write
//   err_count                       : saturating count of dropped requests
interface lc3_mem_model_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int ERR_W  = 8
);
  logic              instrmem_rd;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] Instr_dout;
  logic              complete_instr;
  logic              data_req;
  logic              Data_rd;
  logic [ADDR_W-1:0] Data_addr;
  logic [DATA_W-1:0] Data_din;
  logic [DATA_W-1:0] Data_dout;
  logic              complete_data;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic [ERR_W-1:0]  err_count;

  modport slave (
    input  instrmem_rd, pc, data_req, Data_rd, Data_addr, Data_din,
           load_en, load_addr, load_data,
    output Instr_dout, complete_instr, Data_dout, complete_data, err_count
  );

  modport master (
    output instrmem_rd, pc, data_req, Data_rd, Data_addr, Data_din,
           load_en, load_addr, load_data,
    input  Instr_dout, complete_instr, Data_dout, complete_data, err_count
  );
endinterface

// File: rtl/lc3_mem_model.sv
// lc3_mem_model
// Cycle-accurate instruction/data memory responder for the LC3 bench. Each
// port (I and D) accepts one outstanding request, answers after a fixed
// latency with a one-cycle completion pulse, and counts requests that arrive
// while the port is still busy. A backdoor load port preloads the array.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; clears FSMs/outputs, not the array
//   bus   : lc3_mem_model_if.slave (fetch, data, load ports, err_count)
// Optional feature macro: LC3_MEM_RANDOM_STALL_EN
//   When defined, a 16-bit LFSR (seed 16'hACE1) adds 0-3 extra cycles of
//   latency per accepted request, taken from lfsr[1:0] at acceptance.
module lc3_mem_model #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int IMEM_LAT   = 1,
  parameter int DMEM_LAT   = 2,
  parameter int ERR_W      = 8
) (
  input logic            clock,
  input logic            reset,
  lc3_mem_model_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] I_LAT_M1 = CNT_W'(IMEM_LAT - 1);
  localparam logic [CNT_W-1:0] D_LAT_M1 = CNT_W'(DMEM_LAT - 1);
  localparam logic [ERR_W:0]   ERR_MAX  = {1'b0, {ERR_W{1'b1}}};

  typedef enum logic {IDLE, BUSY} port_state_t;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  port_state_t       i_state, d_state;
  logic [CNT_W-1:0]  i_cnt, d_cnt;
  logic [DATA_W-1:0] i_rdata, d_rdata;
  logic              d_is_read;
  logic [1:0]        stall_extra;

  // Upper address bits are ignored so addresses alias modulo the depth.
  logic [DEPTH_LOG2-1:0] i_idx, d_idx, l_idx;
  assign i_idx = bus.pc[DEPTH_LOG2-1:0];
  assign d_idx = bus.Data_addr[DEPTH_LOG2-1:0];
  assign l_idx = bus.load_addr[DEPTH_LOG2-1:0];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.pc[ADDR_W-1:DEPTH_LOG2],
                              bus.Data_addr[ADDR_W-1:DEPTH_LOG2],
                              bus.load_addr[ADDR_W-1:DEPTH_LOG2]};

`ifdef LC3_MEM_RANDOM_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11; its low two bits give the extra stall
  // applied to whichever request is accepted at the next edge.
  logic [15:0] lfsr;
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end
  assign stall_extra = lfsr[1:0];
`else
  assign stall_extra = 2'b00;
`endif

  logic [CNT_W-1:0] i_lat_m1, d_lat_m1;
  assign i_lat_m1 = I_LAT_M1 + CNT_W'(stall_extra);
  assign d_lat_m1 = D_LAT_M1 + CNT_W'(stall_extra);

  // A port is in its completion cycle when BUSY with the counter at zero;
  // that cycle may accept a new request, any other BUSY cycle drops it.
  logic i_done, d_done, i_accept, d_accept, i_drop, d_drop;
  assign i_done   = (i_state == BUSY) && (i_cnt == '0);
  assign d_done   = (d_state == BUSY) && (d_cnt == '0);
  assign i_accept = bus.instrmem_rd && ((i_state == IDLE) || i_done);
  assign d_accept = bus.data_req    && ((d_state == IDLE) || d_done);
  assign i_drop   = bus.instrmem_rd && (i_state == BUSY) && !i_done;
  assign d_drop   = bus.data_req    && (d_state == BUSY) && !d_done;

  // Array writes: the backdoor load is issued first so that a D-write to the
  // same address in the same cycle overrides it. D-writes commit at
  // acceptance, so an abandoned write is still in the array.
  always_ff @(posedge clock) begin
    if (bus.load_en) begin
      mem[l_idx] <= bus.load_data;
    end
    if (!reset && d_accept && !bus.Data_rd) begin
      mem[d_idx] <= bus.Data_din;
    end
  end

  // I-port FSM. Read data is sampled at acceptance (so a same-edge D-write
  // is not seen). The pulse and dout are registered one edge ahead of the
  // completion cycle, so they line up with the BUSY/cnt==0 cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      i_state            <= IDLE;
      i_cnt              <= '0;
      i_rdata            <= '0;
      bus.complete_instr <= 1'b0;
      bus.Instr_dout     <= '0;
    end else begin
      bus.complete_instr <= 1'b0;
      if (i_accept) begin
        i_state <= BUSY;
        i_cnt   <= i_lat_m1;
        i_rdata <= mem[i_idx];
        if (i_lat_m1 == '0) begin
          bus.complete_instr <= 1'b1;
          bus.Instr_dout     <= mem[i_idx];
        end
      end else if (i_state == BUSY) begin
        if (i_cnt == '0) begin
          i_state <= IDLE;
        end else begin
          i_cnt <= i_cnt - 1'b1;
          if (i_cnt == CNT_W'(1)) begin
            bus.complete_instr <= 1'b1;
            bus.Instr_dout     <= i_rdata;
          end
        end
      end
    end
  end

  // D-port FSM. Same timing as the I-port; writes complete without touching
  // Data_dout.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_state           <= IDLE;
      d_cnt             <= '0;
      d_rdata           <= '0;
      d_is_read         <= 1'b0;
      bus.complete_data <= 1'b0;
      bus.Data_dout     <= '0;
    end else begin
      bus.complete_data <= 1'b0;
      if (d_accept) begin
        d_state   <= BUSY;
        d_cnt     <= d_lat_m1;
        d_rdata   <= mem[d_idx];
        d_is_read <= bus.Data_rd;
        if (d_lat_m1 == '0) begin
          bus.complete_data <= 1'b1;
          if (bus.Data_rd) begin
            bus.Data_dout <= mem[d_idx];
          end
        end
      end else if (d_state == BUSY) begin
        if (d_cnt == '0) begin
          d_state <= IDLE;
        end else begin
          d_cnt <= d_cnt - 1'b1;
          if (d_cnt == CNT_W'(1)) begin
            bus.complete_data <= 1'b1;
            if (d_is_read) begin
              bus.Data_dout <= d_rdata;
            end
          end
        end
      end
    end
  end

  // Both ports can drop a request in the same cycle, so the sum is formed one
  // bit wider and clamped at the all-ones value.
  logic [ERR_W:0] err_sum;
  assign err_sum = {1'b0, bus.err_count} + (ERR_W+1)'(i_drop) + (ERR_W+1)'(d_drop);

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.err_count <= '0;
    end else if (err_sum > ERR_MAX) begin
      bus.err_count <= {ERR_W{1'b1}};
    end else begin
      bus.err_count <= err_sum[ERR_W-1:0];
    end
  end

endmodule

// File: tb/tb_lc3_mem_model.sv
// tb_lc3_mem_model
// Bench for lc3_mem_model. dut1 uses default parameters (IMEM_LAT=1,
// DMEM_LAT=2, ERR_W=8) and is driven from a cycle table; dut2 (DMEM_LAT=4,
// ERR_W=2) covers counter saturation and reset during an access.
// Inputs are driven and outputs sampled on the falling edge.
module tb_lc3_mem_model;

  logic clock;
  logic reset;
  logic reset2;

  lc3_mem_model_if #(.ADDR_W(16), .DATA_W(16), .ERR_W(8)) bus1 ();
  lc3_mem_model_if #(.ADDR_W(16), .DATA_W(16), .ERR_W(2)) bus2 ();

  lc3_mem_model #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10),
    .IMEM_LAT(1), .DMEM_LAT(2), .ERR_W(8)
  ) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  lc3_mem_model #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10),
    .IMEM_LAT(1), .DMEM_LAT(4), .ERR_W(2)
  ) u_dut2 (
    .clock (clock),
    .reset (reset2),
    .bus   (bus2.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // One row per cycle: inputs driven at that falling edge, and the outputs
  // expected to be visible at the same falling edge.
  typedef struct {
    logic        irq;
    logic [15:0] pc;
    logic        dreq;
    logic        drd;
    logic [15:0] daddr;
    logic [15:0] ddin;
    logic        ld;
    logic [15:0] laddr;
    logic [15:0] ldata;
    logic        eci;
    logic [15:0] eidout;
    logic        ecd;
    logic [15:0] eddout;
    logic [7:0]  eerr;
  } vec_t;

  vec_t vecs [0:22];

  function automatic vec_t row(
    input logic irq, input logic [15:0] pc,
    input logic dreq, input logic drd, input logic [15:0] daddr, input logic [15:0] ddin,
    input logic ld, input logic [15:0] laddr, input logic [15:0] ldata,
    input logic eci, input logic [15:0] eidout,
    input logic ecd, input logic [15:0] eddout, input logic [7:0] eerr);
    vec_t v;
    v.irq = irq; v.pc = pc; v.dreq = dreq; v.drd = drd; v.daddr = daddr;
    v.ddin = ddin; v.ld = ld; v.laddr = laddr; v.ldata = ldata;
    v.eci = eci; v.eidout = eidout; v.ecd = ecd; v.eddout = eddout; v.eerr = eerr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus1.instrmem_rd = v.irq;
    bus1.pc          = v.pc;
    bus1.data_req    = v.dreq;
    bus1.Data_rd     = v.drd;
    bus1.Data_addr   = v.daddr;
    bus1.Data_din    = v.ddin;
    bus1.load_en     = v.ld;
    bus1.load_addr   = v.laddr;
    bus1.load_data   = v.ldata;
  endtask

  task automatic idle2();
    bus2.instrmem_rd = 1'b0;
    bus2.pc          = 16'h0;
    bus2.data_req    = 1'b0;
    bus2.Data_rd     = 1'b0;
    bus2.Data_addr   = 16'h0;
    bus2.Data_din    = 16'h0;
    bus2.load_en     = 1'b0;
    bus2.load_addr   = 16'h0;
    bus2.load_data   = 16'h0;
  endtask

  task automatic checkReset1(input string tag);
    checkOutput({tag, " Instr_dout"},     32'(bus1.Instr_dout),     32'h0);
    checkOutput({tag, " complete_instr"}, 32'(bus1.complete_instr), 32'h0);
    checkOutput({tag, " Data_dout"},      32'(bus1.Data_dout),      32'h0);
    checkOutput({tag, " complete_data"},  32'(bus1.complete_data),  32'h0);
    checkOutput({tag, " err_count"},      32'(bus1.err_count),      32'h0);
  endtask

  task automatic checkReset2(input string tag);
    checkOutput({tag, " Instr_dout"},     32'(bus2.Instr_dout),     32'h0);
    checkOutput({tag, " complete_instr"}, 32'(bus2.complete_instr), 32'h0);
    checkOutput({tag, " Data_dout"},      32'(bus2.Data_dout),      32'h0);
    checkOutput({tag, " complete_data"},  32'(bus2.complete_data),  32'h0);
    checkOutput({tag, " err_count"},      32'(bus2.err_count),      32'h0);
  endtask

`ifdef LC3_MEM_RANDOM_STALL_EN
  // Reference LFSR, stepped on the same edges as the DUT's.
  logic [15:0] ref_lfsr;
  always @(posedge clock) begin
    if (reset) ref_lfsr <= 16'hACE1;
    else       ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end
`endif

  initial begin
    vec_t idle_v;
    idle_v = row(0,16'h0, 0,0,16'h0,16'h0, 0,16'h0,16'h0, 0,16'h0,0,16'h0,8'd0);
    applyStimulus(idle_v);
    idle2();
    reset  = 1'b1;
    reset2 = 1'b1;

    //            irq pc        dreq rd addr     din       ld laddr    ldata     eci eidout   ecd eddout   err
    vecs[0]  = row(0, 16'h0000, 0,0, 16'h0000, 16'h0000, 1, 16'h0003, 16'h1234, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[1]  = row(1, 16'h0003, 0,0, 16'h0000, 16'h0000, 1, 16'h0020, 16'hAAAA, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[2]  = row(0, 16'h0000, 0,0, 16'h0000, 16'h0000, 1, 16'h0005, 16'h0F0F, 1, 16'h1234, 0, 16'h0000, 0);
    vecs[3]  = row(0, 16'h0000, 1,0, 16'h0010, 16'hBEEF, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0);
    vecs[4]  = row(0, 16'h0000, 0,0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0);
    vecs[5]  = row(0, 16'h0000, 1,1, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h1234, 1, 16'h0000, 0);
    vecs[6]  = row(0, 16'h0000, 0,0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0, 16'h0000, 0);
    vecs[7]  = row(1, 16'h0020, 1,0, 16'h0020, 16'h5555, 0, 16'h0000, 16'h0000, 0, 16'h1234, 1, 16'hBEEF, 0);
    vecs[8]  = row(1, 16'h0020, 0,0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'hAAAA, 0, 16'hBEEF, 0);
    vecs[9]  = row(1, 16'h0405, 0,0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h5555, 1, 16'hBEEF, 0);
    vecs[10] = row(0, 16'h0000, 1,1, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0F0F, 0, 16'hBEEF, 0);
    vecs[11] = row(0, 16'h0000, 1,1, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0F0F, 0, 16'hBEEF, 0);
    vecs[12] = row(0, 16'h0000, 1,1, 16'h0020, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0F0F, 1, 16'hBEEF, 1);
    vecs[13] = row(0, 16'h0000, 1,1, 16'h0020, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0F0F, 0, 16'hBEEF, 1);
    vecs[14] = row(0, 16'h0000, 1,1, 16'h0003, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0F0F, 1, 16'h5555, 2);
    vecs[15] = row(0, 16'h0000, 1,1, 16'h0003, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0F0F, 0, 16'h5555, 2);
    vecs[16] = row(0, 16'h0000, 0,0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0F0F, 1, 16'h1234, 3);
    vecs[17] = row(0, 16'h0000, 1,0, 16'h0030, 16'h7777, 1, 16'h0030, 16'h1111, 0, 16'h0F0F, 0, 16'h1234, 3);
    vecs[18] = row(1, 16'h0030, 0,0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0F0F, 0, 16'h1234, 3);
    vecs[19] = row(0, 16'h0000, 1,1, 16'h0030, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h7777, 1, 16'h1234, 3);
    vecs[20] = row(0, 16'h0000, 0,0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h7777, 0, 16'h1234, 3);
    vecs[21] = row(0, 16'h0000, 0,0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h7777, 1, 16'h7777, 3);
    vecs[22] = row(0, 16'h0000, 0,0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h7777, 0, 16'h7777, 3);

    repeat (3) @(negedge clock);
    checkReset1("reset1");
    checkReset2("reset2");
    reset  = 1'b0;
    reset2 = 1'b0;

`ifdef LC3_MEM_RANDOM_STALL_EN
    // Preload one word, then measure each fetch latency against the model.
    @(negedge clock);
    bus1.load_en = 1'b1; bus1.load_addr = 16'h0003; bus1.load_data = 16'h1234;
    @(negedge clock);
    bus1.load_en = 1'b0;
    for (int n = 0; n < 100; n++) begin
      int exp_lat;
      int lat;
      @(negedge clock);
      bus1.instrmem_rd = 1'b1;
      bus1.pc          = 16'h0003;
      exp_lat          = 1 + int'(ref_lfsr[1:0]);
      @(negedge clock);
      bus1.instrmem_rd = 1'b0;
      lat = 1;
      while (!bus1.complete_instr && lat < 8) begin
        @(negedge clock);
        lat++;
      end
      checkOutput($sformatf("stall fetch%0d latency", n), 32'(lat), 32'(exp_lat));
    end
    checkOutput("stall Instr_dout", 32'(bus1.Instr_dout), 32'h1234);
`else
    // dut1: cycle table covering preload, fetch, write/read, ordering,
    // address wrap, overlap counting and load/write collision.
    for (int k = 0; k <= 22; k++) begin
      @(negedge clock);
      applyStimulus(vecs[k]);
      checkOutput($sformatf("row%0d complete_instr", k), 32'(bus1.complete_instr), 32'(vecs[k].eci));
      checkOutput($sformatf("row%0d Instr_dout", k),     32'(bus1.Instr_dout),     32'(vecs[k].eidout));
      checkOutput($sformatf("row%0d complete_data", k),  32'(bus1.complete_data),  32'(vecs[k].ecd));
      checkOutput($sformatf("row%0d Data_dout", k),      32'(bus1.Data_dout),      32'(vecs[k].eddout));
      checkOutput($sformatf("row%0d err_count", k),      32'(bus1.err_count),      32'(vecs[k].eerr));
    end
    applyStimulus(idle_v);

    // dut2: data_req held 7 cycles with DMEM_LAT=4 gives 5 drops; a 2-bit
    // counter must stop at 3.
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      bus2.data_req  = (k < 7);
      bus2.Data_rd   = 1'b0;
      bus2.Data_addr = 16'h0001;
      bus2.Data_din  = 16'h0000;
      if (k == 4) begin
        checkOutput("sat complete_data k4", 32'(bus2.complete_data), 32'h1);
        checkOutput("sat err_count k4",     32'(bus2.err_count),     32'h3);
      end
      if (k == 8) checkOutput("sat err_count k8", 32'(bus2.err_count), 32'h3);
    end
    idle2();

    // dut2: reset one cycle after accepting a write; no completion may
    // follow, but the write and an earlier preload must stay in the array.
    @(negedge clock);
    reset2 = 1'b1;
    @(negedge clock);
    reset2 = 1'b0;
    checkReset2("rst2 after sat");
    bus2.load_en = 1'b1; bus2.load_addr = 16'h0007; bus2.load_data = 16'hCAFE;
    @(negedge clock);
    idle2();
    bus2.data_req = 1'b1; bus2.Data_rd = 1'b0; bus2.Data_addr = 16'h0008; bus2.Data_din = 16'hD00D;
    @(negedge clock);
    idle2();
    reset2 = 1'b1;
    @(negedge clock);
    reset2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("midrst complete_data c%0d", k), 32'(bus2.complete_data), 32'h0);
      if (k == 0) checkReset2("midrst");
      @(negedge clock);
    end
    bus2.instrmem_rd = 1'b1; bus2.pc = 16'h0007;
    @(negedge clock);
    checkOutput("midrst preload complete_instr", 32'(bus2.complete_instr), 32'h1);
    checkOutput("midrst preload Instr_dout",     32'(bus2.Instr_dout),     32'hCAFE);
    bus2.pc = 16'h0408;
    @(negedge clock);
    bus2.instrmem_rd = 1'b0;
    checkOutput("midrst committed write Instr_dout", 32'(bus2.Instr_dout), 32'hD00D);
    @(negedge clock);
    checkOutput("midrst complete_data final", 32'(bus2.complete_data), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
